divider_32: RTL

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the divide counterpart of the pipelined 32x32 multiplier in the core's muldiv unit. It accepts one operation at a time through a start/busy/done handshake and retires one quotient bit per cycle. It returns the 32-bit quotient or remainder selected by `op`, including RISC-V-mandated divide-by-zero and overflow results.

---
 rtl/divider_32.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/divider_32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : divider_32                                                      |
// | Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. |
// |            One quotient bit per cycle, start/busy/done handshake, with the |
// |            RISC-V divide-by-zero and signed-overflow results produced      |
// |            directly from IDLE.                                             |
// | Ports    : clk    - rising-edge clock                                      |
// |            reset  - synchronous active-high reset                          |
// |            flush  - synchronous abort of the in-flight operation           |
// |            start  - request, sampled only while busy=0                     |
// |            op     - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU          |
// |            D_inA  - dividend (rs1)                                         |
// |            D_inB  - divisor (rs2)                                          |
// |            busy   - operation in flight                                    |
// |            done   - one-cycle pulse, R valid                               |
// |            R      - result, held until the next accepted start             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module divider_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] D_inA,
  input  logic [31:0] D_inB,
  output logic        busy,
  output logic        done,
  output logic [31:0] R
);

  localparam logic [31:0] C_INT_MIN = 32'h8000_0000;
  localparam logic [31:0] C_ALL_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_op_rem;   // op[1]: 1 selects remainder
  logic [32:0] r_rem;      // partial remainder
  logic [31:0] r_dvd;      // dividend magnitude, becomes the quotient
  logic [31:0] r_dvs;      // divisor magnitude
  logic        r_qsign;
  logic        r_rsign;
  logic [4:0]  r_count;
  logic [31:0] r_result;

  logic        w_signed;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_special_res;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic        w_neg;

  // Operand decode for the IDLE decision
  assign w_signed   = ~op[0];
  assign w_div_zero = (D_inB == 32'd0);
  assign w_ovf      = w_signed && (D_inA == C_INT_MIN) && (D_inB == C_ALL_ONE);
  assign w_special  = w_div_zero || w_ovf;

  always_comb begin
    w_special_res = 32'd0;
    if (w_div_zero) begin
      w_special_res = op[1] ? D_inA : C_ALL_ONE;
    end else begin
      w_special_res = op[1] ? 32'd0 : C_INT_MIN;
    end
  end

  // |INT_MIN| wraps to 0x80000000, which is the correct unsigned magnitude.
  assign w_abs_a = (w_signed && D_inA[31]) ? (~D_inA + 32'd1) : D_inA;
  assign w_abs_b = (w_signed && D_inB[31]) ? (~D_inB + 32'd1) : D_inB;

  // Restoring step: one extra headroom bit makes the trial sign explicit.
  assign w_shift = {r_rem, r_dvd[31]};
  assign w_diff  = w_shift - {2'b00, r_dvs};
  assign w_neg   = w_diff[33];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_special ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_count == 5'd31) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath; flush freezes everything so R keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_rem <= 1'b0;
      r_rem    <= 33'd0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_count  <= 5'd0;
      r_result <= 32'd0;
    end else if (!flush) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op_rem <= op[1];
            r_dvd    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_qsign  <= w_signed && (D_inA[31] ^ D_inB[31]);
            r_rsign  <= w_signed && D_inA[31];
            r_rem    <= 33'd0;
            r_count  <= 5'd0;
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end
        CALC: begin
          r_rem   <= w_neg ? w_shift[32:0] : w_diff[32:0];
          r_dvd   <= {r_dvd[30:0], ~w_neg};
          r_count <= r_count + 5'd1;
        end
        FIX: begin
          if (r_op_rem) begin
            r_result <= r_rsign ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
          end else begin
            r_result <= r_qsign ? (~r_dvd + 32'd1) : r_dvd;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign R = r_result;

endmodule
`default_nettype wire
